// File: rtl/la_trig_pkg.sv
// Shared trigger definitions: FSM state encoding, channel config bit
// positions, reset config value and the per-channel qualification function.
package la_trig_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WAIT      = 2'd1;
  localparam state_t ST_TRIGGERED = 2'd2;

  localparam int CFG_W         = 5;
  localparam int CFG_DONT_CARE = 0;
  localparam int CFG_LOW_LVL   = 1;
  localparam int CFG_HIGH_LVL  = 2;
  localparam int CFG_NEG_L     = 3;
  localparam int CFG_POS_H     = 4;

  localparam logic [CFG_W-1:0] CFG_DEFAULT = 5'h01;

  // OR of every enabled term; an all-zero config never qualifies.
  function automatic logic chan_qualify(input logic [CFG_W-1:0] cfg,
                                        input logic s2_l, input logic s2_h,
                                        input logic s3_l, input logic s3_h);
    chan_qualify = cfg[CFG_DONT_CARE]
                 | (cfg[CFG_LOW_LVL]  & ~s2_l)
                 | (cfg[CFG_HIGH_LVL] &  s2_h)
                 | (cfg[CFG_NEG_L]    &  s3_l & ~s2_l)
                 | (cfg[CFG_POS_H]    & ~s3_h &  s2_h);
  endfunction

endpackage

// File: rtl/chan_trig_unit_if.sv
// Configuration register bus of the channel trigger unit.
interface chan_trig_unit_if;
  logic       cfg_wr;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [7:0] cfg_rd_data;

  modport master (output cfg_wr, output cfg_addr, output cfg_data, input cfg_rd_data);
  modport slave  (input cfg_wr, input cfg_addr, input cfg_data, output cfg_rd_data);
endinterface

// File: rtl/chan_trig_qual.sv
// One analog channel pair: 2-flop synchronizer, history flop and the
// combinational qualification against the channel config.
module chan_trig_qual
  import la_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chl,
  input  logic             chh,
  input  logic [CFG_W-1:0] cfg,
  output logic             chtrig
);

  // bit 0 carries CHL, bit 1 carries CHH
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] s3_q, s3_d;

  always_comb begin
    s1_d = {chh, chl};
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
      s3_q <= 2'b00;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  always_comb chtrig = chan_qualify(cfg, s2_q[0], s2_q[1], s3_q[0], s3_q[1]);

endmodule

// File: rtl/chan_trig_unit.sv
// Multi-channel analog trigger: per-channel qualification, config registers
// and an occurrence-counting trigger FSM with sticky flag and one-cycle pulse.
module chan_trig_unit
  import la_trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   CHL,
  input  logic [NUM_CH-1:0]   CHH,
  chan_trig_unit_if.slave     cfg_bus,
  input  logic                armed,
  input  logic                protTrig,
  input  logic                clr_trig,
  output logic [NUM_CH-1:0]   CHTrig,
  output logic                trig_pulse,
  output logic                triggered
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CFG_W-1:0] ch_cfg_q [NUM_CH];
  logic [CFG_W-1:0] ch_cfg_d [NUM_CH];
  logic [CNT_W-1:0] count_reg_q, count_reg_d;
  logic [CNT_W-1:0] occ_cnt_q, occ_cnt_d;
  state_t           state_q, state_d;
  logic             match_q, match_d;
  logic             trig_pulse_q, trig_pulse_d;
  logic             triggered_q, triggered_d;

  logic             match_s, rise_s, reach_s;
  logic [CNT_W-1:0] thresh_s, cnt_inc_s;
  logic [7:0]       rd_data_s;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_bus.cfg_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_trig_qual u_qual (
      .clk    (clk),
      .rst_n  (rst_n),
      .chl    (CHL[g]),
      .chh    (CHH[g]),
      .cfg    (ch_cfg_q[g]),
      .chtrig (CHTrig[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_bus.cfg_wr && (cfg_bus.cfg_addr == 4'(i))) begin
        ch_cfg_d[i] = cfg_bus.cfg_data[CFG_W-1:0];
      end else begin
        ch_cfg_d[i] = ch_cfg_q[i];
      end
    end
    if (cfg_bus.cfg_wr && (cfg_bus.cfg_addr == 4'(NUM_CH))) begin
      count_reg_d = cfg_bus.cfg_data[CNT_W-1:0];
    end else begin
      count_reg_d = count_reg_q;
    end
  end

  // Readback is an OR of address-gated registers; unmapped addresses read zero.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data_s = rd_data_s | ({3'b000, ch_cfg_q[i]} & {8{cfg_bus.cfg_addr == 4'(i)}});
    end
    rd_data_s = rd_data_s | (8'(count_reg_q) & {8{cfg_bus.cfg_addr == 4'(NUM_CH)}});
  end

  assign cfg_bus.cfg_rd_data = rd_data_s;

  always_comb begin
    match_s   = (&CHTrig) & protTrig & armed;
    rise_s    = match_s & ~match_q;
    thresh_s  = (count_reg_q == CNT_ZERO) ? CNT_ONE : count_reg_q;
    cnt_inc_s = (occ_cnt_q == CNT_MAX) ? occ_cnt_q : occ_cnt_q + CNT_ONE;
    reach_s   = (cnt_inc_s >= thresh_s);
  end

  // The edge-detect history is held low while idle, so a match already
  // present when the engine arms counts as the first rising match.
  always_comb begin
    state_d      = state_q;
    occ_cnt_d    = occ_cnt_q;
    trig_pulse_d = 1'b0;
    match_d      = match_s;
    case (state_q)
      ST_IDLE: begin
        occ_cnt_d = CNT_ZERO;
        match_d   = 1'b0;
        if (armed) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!armed || clr_trig) begin
          state_d   = ST_IDLE;
          occ_cnt_d = CNT_ZERO;
        end else if (rise_s) begin
          occ_cnt_d = cnt_inc_s;
          if (reach_s) begin
            state_d      = ST_TRIGGERED;
            trig_pulse_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_TRIGGERED: begin
        if (!armed || clr_trig) begin
          state_d   = ST_IDLE;
          occ_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_TRIGGERED;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        occ_cnt_d = CNT_ZERO;
      end
    endcase
    triggered_d = (state_d == ST_TRIGGERED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cfg_q[i] <= CFG_DEFAULT;
      end
      count_reg_q  <= CNT_ONE;
      occ_cnt_q    <= CNT_ZERO;
      state_q      <= ST_IDLE;
      match_q      <= 1'b0;
      trig_pulse_q <= 1'b0;
      triggered_q  <= 1'b0;
    end else begin
      ch_cfg_q     <= ch_cfg_d;
      count_reg_q  <= count_reg_d;
      occ_cnt_q    <= occ_cnt_d;
      state_q      <= state_d;
      match_q      <= match_d;
      trig_pulse_q <= trig_pulse_d;
      triggered_q  <= triggered_d;
    end
  end

  assign trig_pulse = trig_pulse_q;
  assign triggered  = triggered_q;

endmodule

// File: tb/tb_chan_trig_unit.sv
// Scoreboard bench for chan_trig_unit: directed stimulus queues the edge at
// which each trig_pulse is due; a monitor pops and compares on every pulse.
module tb_chan_trig_unit;
  import la_trig_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] chl0, chh0, chtrig0;
  logic       arm0, prot0, clr0, pulse0, trig0;
  logic [7:0] chl1, chh1, chtrig1;
  logic       arm1, prot1, clr1, pulse1, trig1;

  chan_trig_unit_if bus0 ();
  chan_trig_unit_if bus1 ();

  chan_trig_unit dut0 (
    .clk(clk), .rst_n(rst_n), .CHL(chl0), .CHH(chh0), .cfg_bus(bus0),
    .armed(arm0), .protTrig(prot0), .clr_trig(clr0),
    .CHTrig(chtrig0), .trig_pulse(pulse0), .triggered(trig0)
  );

  chan_trig_unit #(.NUM_CH(8), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .CHL(chl1), .CHH(chh1), .cfg_bus(bus1),
    .armed(arm1), .protTrig(prot1), .clr_trig(clr1),
    .CHTrig(chtrig1), .trig_pulse(pulse1), .triggered(trig1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q0[$];
  int exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input bit which, input logic [3:0] a, input logic [7:0] d);
    if (which) begin
      bus1.cfg_wr = 1'b1; bus1.cfg_addr = a; bus1.cfg_data = d;
    end else begin
      bus0.cfg_wr = 1'b1; bus0.cfg_addr = a; bus0.cfg_data = d;
    end
    @(negedge clk);
    bus0.cfg_wr = 1'b0;
    bus1.cfg_wr = 1'b0;
  endtask

  task automatic rd_chk(input bit which, input logic [3:0] a, input logic [7:0] exp, input string name);
    logic [7:0] rd;
    if (which) bus1.cfg_addr = a; else bus0.cfg_addr = a;
    #1;
    rd = which ? bus1.cfg_rd_data : bus0.cfg_rd_data;
    chk(name, 32'(rd), 32'(exp));
    @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest queued expected edge.
  initial forever begin
    int e;
    @(negedge clk);
    if (pulse0 === 1'b1) begin
      if (exp_q0.size() == 0) chk("dut0_pulse_expected", 32'(exp_q0.size()), 32'd1);
      else begin
        e = exp_q0.pop_front();
        chk("dut0_pulse_edge", 32'(cyc), 32'(e));
      end
    end
    if (pulse1 === 1'b1) begin
      if (exp_q1.size() == 0) chk("dut1_pulse_expected", 32'(exp_q1.size()), 32'd1);
      else begin
        e = exp_q1.pop_front();
        chk("dut1_pulse_edge", 32'(cyc), 32'(e));
      end
    end
  end

  initial begin
    int pin;
    rst_n = 1'b0;
    chl0 = 5'h00; chh0 = 5'h00; arm0 = 1'b0; prot0 = 1'b0; clr0 = 1'b0;
    chl1 = 8'h00; chh1 = 8'h00; arm1 = 1'b0; prot1 = 1'b0; clr1 = 1'b0;
    bus0.cfg_wr = 1'b0; bus0.cfg_addr = 4'd0; bus0.cfg_data = 8'h00;
    bus1.cfg_wr = 1'b0; bus1.cfg_addr = 4'd0; bus1.cfg_data = 8'h00;
    wait_cyc(3);

    chk("rst_pulse", 32'(pulse0), 32'd0);
    chk("rst_triggered", 32'(trig0), 32'd0);
    chk("rst_chtrig", 32'(chtrig0), 32'h1f);
    rd_chk(1'b0, 4'd0, 8'h01, "rst_rd_ch1");
    rd_chk(1'b0, 4'd5, 8'h01, "rst_rd_count");
    rd_chk(1'b0, 4'd9, 8'h00, "rd_unmapped");
    rd_chk(1'b1, 4'd8, 8'h01, "rst_rd_count_dut1");
    rst_n = 1'b1;
    wait_cyc(2);

    // Arm with everything don't-care: pulse on the 2nd edge, flag sticks.
    arm0 = 1'b1; prot0 = 1'b1;
    exp_q0.push_back(cyc + 2);
    wait_cyc(4);
    chk("arm_triggered", 32'(trig0), 32'd1);
    chk("arm_pulse_one_cycle", 32'(pulse0), 32'd0);

    // Clear, hold protTrig low 100 cycles, then retrigger one edge after it rises.
    clr0 = 1'b1; prot0 = 1'b0;
    @(negedge clk);
    clr0 = 1'b0;
    chk("clr_triggered", 32'(trig0), 32'd0);
    chk("clr_state_idle", 32'(dut0.state_q), 32'(ST_IDLE));
    wait_cyc(100);
    chk("prot_low_no_trigger", 32'(trig0), 32'd0);
    prot0 = 1'b1;
    exp_q0.push_back(cyc + 1);
    wait_cyc(3);
    chk("retriggered", 32'(trig0), 32'd1);
    arm0 = 1'b0; prot0 = 1'b0;
    @(negedge clk);
    chk("disarm_triggered", 32'(trig0), 32'd0);

    // Ch1 posedge on CHH: CHTrig[0] high one cycle, pulse 3 edges after pin.
    cfg_write(1'b0, 4'd0, 8'h10);
    rd_chk(1'b0, 4'd0, 8'h10, "posedge_rd_ch1");
    chk("posedge_chtrig_idle", 32'(chtrig0), 32'h1e);
    arm0 = 1'b1; prot0 = 1'b1;
    wait_cyc(3);
    chh0[0] = 1'b1;
    pin = cyc;
    exp_q0.push_back(pin + 3);
    @(negedge clk); chk("posedge_chtrig_e1", 32'(chtrig0), 32'h1e);
    @(negedge clk); chk("posedge_chtrig_e2", 32'(chtrig0), 32'h1f);
    @(negedge clk); chk("posedge_chtrig_e3", 32'(chtrig0), 32'h1e);
    chk("posedge_triggered", 32'(trig0), 32'd1);
    arm0 = 1'b0; prot0 = 1'b0; chh0 = 5'h00;
    wait_cyc(4);

    // Count of 3 with CHL negedge qualification: only the 3rd negedge fires.
    cfg_write(1'b0, 4'd5, 8'h03);
    cfg_write(1'b0, 4'd0, 8'h08);
    rd_chk(1'b0, 4'd5, 8'h03, "count_rd");
    chl0[0] = 1'b1;
    wait_cyc(4);
    arm0 = 1'b1; prot0 = 1'b1;
    wait_cyc(3);
    for (int n = 1; n <= 3; n++) begin
      chl0[0] = 1'b0;
      if (n == 3) exp_q0.push_back(cyc + 3);
      wait_cyc(4);
      chk($sformatf("count_triggered_after_%0d", n), 32'(trig0), (n == 3) ? 32'd1 : 32'd0);
      chl0[0] = 1'b1;
      wait_cyc(4);
    end

    // Asynchronous reset mid-operation drops everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_triggered", 32'(trig0), 32'd0);
    chk("midrst_pulse", 32'(pulse0), 32'd0);
    chk("midrst_chtrig", 32'(chtrig0), 32'h1f);
    bus0.cfg_addr = 4'd0;
    #1;
    chk("midrst_rd_ch1", 32'(bus0.cfg_rd_data), 32'h01);
    arm0 = 1'b0; prot0 = 1'b0; chl0 = 5'h00;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);

    // 8-channel, 4-bit counter at 15: 20 rising matches, one pulse at the 15th.
    cfg_write(1'b1, 4'd8, 8'h0f);
    rd_chk(1'b1, 4'd8, 8'h0f, "wide_rd_count");
    arm1 = 1'b1; prot1 = 1'b0;
    wait_cyc(3);
    for (int n = 1; n <= 20; n++) begin
      prot1 = 1'b1;
      if (n == 15) exp_q1.push_back(cyc + 1);
      @(negedge clk);
      prot1 = 1'b0;
      @(negedge clk);
    end
    chk("wide_triggered", 32'(trig1), 32'd1);

    wait_cyc(5);
    chk("sb_drain_dut0", 32'(exp_q0.size()), 32'd0);
    chk("sb_drain_dut1", 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
